// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: prescaled up/down/ping-pong/hold select generator for a 3-to-8 decoder
// Ports: clk, rst (sync, active-high), en (run enable), mode (00 up, 01 down, 10 ping-pong, 11 hold),
//        load/load_val (synchronous start-index load, clamped to LAST),
//        sel (registered select), dir (1 = up), step/wrap (1-cycle strobes alongside the new sel)
module decoder_scan_sequencer #(
  parameter int PRESCALE = 4,
  parameter int LAST = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       dir,
  output logic       step,
  output logic       wrap
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [2:0] L = 3'(LAST);
  localparam logic [PW-1:0] PM = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic act, tick, up, going_up, at_end, nd;
  logic [2:0] ns;
  always_comb begin
    act = en && mode != 2'd3;
    tick = act && pre == PM;
    // while idle the FSM carries no direction, so fall back to the dir register
    up = state == S_IDLE ? dir : state == S_UP;
    going_up = mode == 2'd0 || (mode == 2'd2 && up);
    at_end = going_up ? sel == L : sel == 3'd0;
    // ping-pong reflects off the end without dwelling; up/down wrap around
    ns = going_up ? (at_end ? (mode == 2'd2 ? L - 3'd1 : 3'd0) : sel + 3'd1)
                  : (at_end ? (mode == 2'd2 ? 3'd1 : L) : sel - 3'd1);
    nd = mode == 2'd0 ? 1'b1 : mode == 2'd1 ? 1'b0 :
         (tick && mode == 2'd2 && at_end) ? !up : dir;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= 3'd0;
      dir <= 1'b1;
      step <= 1'b0;
      wrap <= 1'b0;
      pre <= '0;
      state <= S_IDLE;
    end else if (load) begin
      sel <= load_val > L ? L : load_val;
      pre <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      pre <= act ? (tick ? '0 : pre + 1'b1) : pre;
      if (tick) sel <= ns;
      dir <= nd;
      state <= !en ? S_IDLE : nd ? S_UP : S_DOWN;
      step <= tick;
      wrap <= tick && at_end;
    end
  end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: random and directed checks of two sequencer configurations against a reference model
module tb_decoder_scan_sequencer;
  logic clk = 0, rst = 1, en = 0, load = 0;
  logic [1:0] mode = 0;
  logic [2:0] load_val = 0;
  logic [2:0] sel_a, sel_b;
  logic dir_a, dir_b, step_a, step_b, wrap_a, wrap_b;
  int n_cmp = 0, n_bad = 0;
  int m_sel[2] = '{0, 0}, m_pre[2] = '{0, 0}, m_dir[2] = '{1, 1};
  int m_step[2] = '{0, 0}, m_wrap[2] = '{0, 0};
  always #5 clk = ~clk;
  decoder_scan_sequencer #(.PRESCALE(4), .LAST(7)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .sel(sel_a), .dir(dir_a), .step(step_a), .wrap(wrap_a));
  decoder_scan_sequencer #(.PRESCALE(1), .LAST(5)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .sel(sel_b), .dir(dir_b), .step(step_b), .wrap(wrap_b));
  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic model(int k, int p, int l);
    int s, d, n, nd;
    bit act, tick;
    if (rst) begin
      m_sel[k] = 0; m_dir[k] = 1; m_pre[k] = 0; m_step[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_sel[k] = int'(load_val) > l ? l : int'(load_val);
      m_pre[k] = 0; m_step[k] = 0; m_wrap[k] = 0;
    end else begin
      act = en && mode != 3;
      tick = act && m_pre[k] == p - 1;
      nd = mode == 0 ? 1 : mode == 1 ? 0 : m_dir[k];
      m_step[k] = tick; m_wrap[k] = 0;
      s = m_sel[k];
      if (tick) begin
        if (mode == 0) begin
          m_wrap[k] = s == l; m_sel[k] = (s + 1) % (l + 1);
        end else if (mode == 1) begin
          m_wrap[k] = s == 0; m_sel[k] = (s + l) % (l + 1);
        end else begin
          d = m_dir[k] ? 1 : -1;
          n = s + d;
          if (n < 0 || n > l) begin
            m_wrap[k] = 1; nd = 1 - m_dir[k]; n = s - d;
          end
          m_sel[k] = n;
        end
      end
      if (act) m_pre[k] = (m_pre[k] + 1) % p;
      m_dir[k] = nd;
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model(0, 4, 7);
    model(1, 1, 5);
    @(negedge clk);
    chk("sel_a", int'(sel_a), m_sel[0]);
    chk("dir_a", int'(dir_a), m_dir[0]);
    chk("step_a", int'(step_a), m_step[0]);
    chk("wrap_a", int'(wrap_a), m_wrap[0]);
    chk("sel_b", int'(sel_b), m_sel[1]);
    chk("dir_b", int'(dir_b), m_dir[1]);
    chk("step_b", int'(step_b), m_step[1]);
    chk("wrap_b", int'(wrap_b), m_wrap[1]);
  endtask
  task automatic run(int n, bit e, logic [1:0] m);
    en = e; mode = m;
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    cycle();
    cycle();
    chk("rst_sel", int'(sel_a), 0);
    chk("rst_dir", int'(dir_a), 1);
    rst = 0;
    run(40, 1, 2'd0);
    load = 1; load_val = 3'd2; cycle(); load = 0;
    run(20, 1, 2'd1);
    load = 1; load_val = 3'd6; cycle(); load = 0;
    run(3, 1, 2'd0);
    run(40, 1, 2'd2);
    load = 1; load_val = 3'd7; cycle(); load = 0;
    chk("clamp_b", int'(sel_b), 5);
    run(2, 1, 2'd0);
    run(10, 0, 2'd0);
    run(6, 1, 2'd0);
    run(12, 1, 2'd3);
    load = 1; load_val = 3'd4; run(1, 1, 2'd1); load = 0;
    run(2, 1, 2'd1);
    rst = 1; load = 1; load_val = 3'd3; cycle(); rst = 0; load = 0;
    chk("rst_load_sel", int'(sel_a), 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) mode = 2'($urandom_range(0, 3));
      en = ($urandom % 8) != 0;
      load = ($urandom % 16) == 0;
      load_val = 3'($urandom);
      rst = ($urandom % 200) == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
